// File: rtl/l1cache_mem_arbiter.sv
// Round-robin arbiter that shares one memory request/response channel between the
// I-cache (client 0) and the D-cache (client 1), with one transaction outstanding.
package Mem;
  typedef logic [31:0]  w_t;
  typedef logic [127:0] line_t;
  typedef logic [27:0]  lineaddr_t;

  typedef struct packed {
    logic      we;
    lineaddr_t addr;
    line_t     data;
  } req_t;
endpackage

// Per-client steering: ready and response beats reach only the current owner.
module l1cache_mem_arbiter_port (
  input  logic    en,
  input  logic    sel,
  input  logic    issue,
  input  logic    resp,
  input  logic    m_req_ready,
  input  logic    m_resp_ack,
  input  Mem::w_t m_resp_data,
  output logic    req_ready,
  output logic    resp_ack,
  output Mem::w_t resp_data
);
  logic own_resp;

  assign own_resp  = en & sel & resp;
  assign req_ready = en & sel & issue & m_req_ready;
  assign resp_ack  = own_resp & m_resp_ack;
  assign resp_data = own_resp ? m_resp_data : '0;
endmodule

module l1cache_mem_arbiter #(
  parameter int   RD_BEATS   = 4,
  parameter int   WR_BEATS   = 1,
  parameter logic RESET_PRIO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           c0_req_valid,
  output logic           c0_req_ready,
  input  logic           c0_req_we,
  input  Mem::lineaddr_t c0_req_addr,
  input  Mem::line_t     c0_req_data,
  output Mem::w_t        c0_resp_data,
  output logic           c0_resp_ack,
  input  logic           c1_req_valid,
  output logic           c1_req_ready,
  input  logic           c1_req_we,
  input  Mem::lineaddr_t c1_req_addr,
  input  Mem::line_t     c1_req_data,
  output Mem::w_t        c1_resp_data,
  output logic           c1_resp_ack,
  output logic           m_req_valid,
  input  logic           m_req_ready,
  output logic           m_req_we,
  output Mem::lineaddr_t m_req_addr,
  output Mem::line_t     m_req_data,
  input  Mem::w_t        m_resp_data,
  input  logic           m_resp_ack,
  output logic           err_stray_ack
);
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [NUM_CLIENTS-1:0]           c_req_valid;
  Mem::req_t [NUM_CLIENTS-1:0]      c_req;
  logic [NUM_CLIENTS-1:0]           c_req_ready;
  logic [NUM_CLIENTS-1:0]           c_resp_ack;
  logic [NUM_CLIENTS-1:0][31:0]     c_resp_data;
  Mem::req_t                        sel_req;
  logic [3:0]                       last_beat;
  logic                             st_issue, st_resp;

  assign c_req_valid = {c1_req_valid, c0_req_valid};
  assign c_req[0]    = {c0_req_we, c0_req_addr, c0_req_data};
  assign c_req[1]    = {c1_req_we, c1_req_addr, c1_req_data};
  assign sel_req     = c_req[owner_q];
  assign last_beat   = we_q ? 4'(WR_BEATS - 1) : 4'(RD_BEATS - 1);
  assign st_issue    = (state_q == ISSUE);
  assign st_resp     = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= RESET_PRIO;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    // Any ack outside RESP, including one coinciding with the ISSUE handshake, is stray.
    err_d   = err_q | (m_resp_ack & ~st_resp);
    case (state_q)
      IDLE: begin
        if (|c_req_valid) begin
          state_d = ISSUE;
          owner_d = (&c_req_valid) ? prio_q : c_req_valid[1];
        end
      end
      ISSUE: begin
        if (m_req_ready) begin
          we_d    = sel_req.we;
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_resp_ack) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == last_beat) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_port
    l1cache_mem_arbiter_port u_port (
      .en          (rst_n),
      .sel         (owner_q == 1'(g)),
      .issue       (st_issue),
      .resp        (st_resp),
      .m_req_ready (m_req_ready),
      .m_resp_ack  (m_resp_ack),
      .m_resp_data (m_resp_data),
      .req_ready   (c_req_ready[g]),
      .resp_ack    (c_resp_ack[g]),
      .resp_data   (c_resp_data[g])
    );
  end

  assign c0_req_ready = c_req_ready[0];
  assign c1_req_ready = c_req_ready[1];
  assign c0_resp_ack  = c_resp_ack[0];
  assign c1_resp_ack  = c_resp_ack[1];
  assign c0_resp_data = c_resp_data[0];
  assign c1_resp_data = c_resp_data[1];

  // Memory-side fields are gated to zero outside ISSUE and while reset is held.
  assign m_req_valid   = rst_n & st_issue;
  assign m_req_we      = m_req_valid & sel_req.we;
  assign m_req_addr    = m_req_valid ? sel_req.addr : '0;
  assign m_req_data    = m_req_valid ? sel_req.data : '0;
  assign err_stray_ack = rst_n & err_q;
endmodule

// File: tb/tb_l1cache_mem_arbiter.sv
// Directed bench for l1cache_mem_arbiter: single read, contention, backpressure,
// write completion, stray acks and reset in the middle of a read.
module tb_l1cache_mem_arbiter;
  logic           clk = 1'b0;
  logic           rst_n;
  logic           c0_req_valid, c0_req_ready, c0_req_we, c0_resp_ack;
  Mem::lineaddr_t c0_req_addr;
  Mem::line_t     c0_req_data;
  Mem::w_t        c0_resp_data;
  logic           c1_req_valid, c1_req_ready, c1_req_we, c1_resp_ack;
  Mem::lineaddr_t c1_req_addr;
  Mem::line_t     c1_req_data;
  Mem::w_t        c1_resp_data;
  logic           m_req_valid, m_req_ready, m_req_we, m_resp_ack, err_stray_ack;
  Mem::lineaddr_t m_req_addr;
  Mem::line_t     m_req_data;
  Mem::w_t        m_resp_data;

  int errors = 0;
  int checks = 0;

  l1cache_mem_arbiter #(.RD_BEATS(4), .WR_BEATS(1), .RESET_PRIO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
    .c0_req_addr(c0_req_addr), .c0_req_data(c0_req_data),
    .c0_resp_data(c0_resp_data), .c0_resp_ack(c0_resp_ack),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
    .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
    .c1_resp_data(c1_resp_data), .c1_resp_ack(c1_resp_ack),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data),
    .m_resp_data(m_resp_data), .m_resp_ack(m_resp_ack),
    .err_stray_ack(err_stray_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    c0_req_valid = 1'b1; c0_req_we = 1'b0; c0_req_addr = '0; c0_req_data = '0;
    c1_req_valid = 1'b0; c1_req_we = 1'b0; c1_req_addr = '0; c1_req_data = '0;
    m_req_ready = 1'b1; m_resp_ack = 1'b1; m_resp_data = 32'h55;
    tick(); tick(); #1;
    chk("rst_m_valid", m_req_valid, 0);
    chk("rst_c0_ready", c0_req_ready, 0);
    chk("rst_c0_ack", c0_resp_ack, 0);
    chk("rst_err", err_stray_ack, 0);

    // Single read from c0
    rst_n = 1'b1; c0_req_valid = 1'b0; m_resp_ack = 1'b0;
    tick();
    c0_req_valid = 1'b1; c0_req_addr = 28'h10; #1;
    chk("rd_idle_m_valid", m_req_valid, 0);
    chk("rd_idle_c0_ready", c0_req_ready, 0);
    tick();
    chk("rd_issue_m_valid", m_req_valid, 1);
    chk("rd_issue_addr", m_req_addr, 28'h10);
    chk("rd_issue_we", m_req_we, 0);
    chk("rd_issue_c0_ready", c0_req_ready, 1);
    chk("rd_issue_c1_ready", c1_req_ready, 0);
    tick();
    c0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      m_resp_ack = 1'b1; m_resp_data = 32'hA0 + i; #1;
      chk("rd_c0_ack", c0_resp_ack, 1);
      chk("rd_c0_data", c0_resp_data, 32'hA0 + i);
      chk("rd_c1_ack", c1_resp_ack, 0);
      chk("rd_m_valid_low", m_req_valid, 0);
    end

    // Stray ack in IDLE right after the terminal beat
    tick();
    m_resp_ack = 1'b1; m_resp_data = 32'hFF; #1;
    chk("stray_c0_ack", c0_resp_ack, 0);
    chk("stray_c1_ack", c1_resp_ack, 0);
    chk("stray_err_before", err_stray_ack, 0);

    // Contention: c1 wins first, then c0, then c1 again
    tick();
    m_resp_ack = 1'b0;
    c0_req_valid = 1'b1; c0_req_addr = 28'h20;
    c1_req_valid = 1'b1; c1_req_addr = 28'h30; #1;
    chk("stray_err_set", err_stray_ack, 1);
    chk("cont_idle_m_valid", m_req_valid, 0);
    tick();
    chk("cont_g1_addr", m_req_addr, 28'h30);
    chk("cont_g1_c1_ready", c1_req_ready, 1);
    chk("cont_g1_c0_ready", c0_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      m_resp_ack = 1'b1; m_resp_data = 32'hB0 + i; #1;
      chk("cont_g1_c1_ack", c1_resp_ack, 1);
      chk("cont_g1_c1_data", c1_resp_data, 32'hB0 + i);
      chk("cont_g1_c0_ack", c0_resp_ack, 0);
      chk("cont_g1_c0_data", c0_resp_data, 0);
    end
    tick();
    m_resp_ack = 1'b0; #1;
    chk("cont_gap_m_valid", m_req_valid, 0);
    tick();
    chk("cont_g2_m_valid", m_req_valid, 1);
    chk("cont_g2_addr", m_req_addr, 28'h20);
    chk("cont_g2_c0_ready", c0_req_ready, 1);
    chk("cont_g2_c1_ready", c1_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      m_resp_ack = 1'b1; m_resp_data = 32'hC0 + i; #1;
      chk("cont_g2_c0_ack", c0_resp_ack, 1);
      chk("cont_g2_c1_ack", c1_resp_ack, 0);
    end
    tick();
    m_resp_ack = 1'b0; c0_req_valid = 1'b0; m_req_ready = 1'b0; #1;
    chk("cont_gap2_m_valid", m_req_valid, 0);

    // Third grant (c1) under backpressure: 5 stalled cycles then accept
    for (int i = 0; i < 6; i++) begin
      tick();
      m_req_ready = (i == 5); #1;
      chk("bp_m_valid", m_req_valid, 1);
      chk("bp_addr", m_req_addr, 28'h30);
      chk("bp_c1_ready", c1_req_ready, (i == 5));
      chk("bp_c0_ready", c0_req_ready, 0);
    end
    tick();
    c1_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      m_resp_ack = 1'b1; m_resp_data = 32'hD0 + i; #1;
      chk("bp_c1_ack", c1_resp_ack, 1);
    end

    // Single-beat write from c1, then a c0 read must be granted
    tick();
    m_resp_ack = 1'b0;
    c1_req_valid = 1'b1; c1_req_we = 1'b1; c1_req_addr = 28'h40;
    c1_req_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0; #1;
    chk("wr_idle_m_valid", m_req_valid, 0);
    tick();
    chk("wr_issue_m_valid", m_req_valid, 1);
    chk("wr_issue_we", m_req_we, 1);
    chk("wr_issue_data", m_req_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
    chk("wr_issue_c1_ready", c1_req_ready, 1);
    tick();
    c1_req_valid = 1'b0; c1_req_we = 1'b0;
    m_resp_ack = 1'b1; m_resp_data = 32'hE0; #1;
    chk("wr_c1_ack", c1_resp_ack, 1);
    chk("wr_c0_ack", c0_resp_ack, 0);
    tick();
    m_resp_ack = 1'b0; c0_req_valid = 1'b1; c0_req_addr = 28'h50; #1;
    chk("wr_done_m_valid", m_req_valid, 0);
    chk("wr_done_c1_ack", c1_resp_ack, 0);
    tick();
    chk("wr_next_m_valid", m_req_valid, 1);
    chk("wr_next_addr", m_req_addr, 28'h50);

    // Reset after 2 of 4 read beats
    tick();
    c0_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      m_resp_ack = 1'b1; m_resp_data = 32'hF0 + i; #1;
      chk("mid_c0_ack", c0_resp_ack, 1);
    end
    tick();
    rst_n = 1'b0; m_resp_ack = 1'b1; #1;
    chk("mid_rst_c0_ack", c0_resp_ack, 0);
    chk("mid_rst_c0_data", c0_resp_data, 0);
    chk("mid_rst_m_valid", m_req_valid, 0);
    chk("mid_rst_err", err_stray_ack, 0);
    tick();
    rst_n = 1'b1; m_resp_ack = 1'b0;
    c0_req_valid = 1'b1; c0_req_addr = 28'h60; #1;
    chk("post_rst_err", err_stray_ack, 0);
    chk("post_rst_m_valid", m_req_valid, 0);
    tick();
    chk("post_rst_issue_addr", m_req_addr, 28'h60);
    chk("post_rst_c0_ready", c0_req_ready, 1);
    tick();
    c0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      m_resp_ack = 1'b1; m_resp_data = 32'h10 + i; #1;
      chk("post_rst_c0_ack", c0_resp_ack, 1);
      chk("post_rst_c0_data", c0_resp_data, 32'h10 + i);
    end
    tick();
    m_resp_ack = 1'b1; #1;
    chk("post_rst_stray_ack", c0_resp_ack, 0);
    tick();
    m_resp_ack = 1'b0; #1;
    chk("post_rst_err_set", err_stray_ack, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
